// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath: sequences the shared ALU, unified memory and register file.
// Outputs are Moore-decoded from state; only PCEn (Zero) and Illegal (Op in DECODE) look at inputs.
module multicycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Op,
  input  logic       Zero,
  output logic [3:0] state,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSrc,
  output logic       Branch,
  output logic       PCEn,
  output logic       Illegal
);

  localparam logic [3:0] FETCH  = 4'd0;
  localparam logic [3:0] DECODE = 4'd1;
  localparam logic [3:0] MEMADR = 4'd2;
  localparam logic [3:0] MEMRD  = 4'd3;
  localparam logic [3:0] MEMWB  = 4'd4;
  localparam logic [3:0] MEMWR  = 4'd5;
  localparam logic [3:0] EXEC   = 4'd6;
  localparam logic [3:0] ALUWB  = 4'd7;
  localparam logic [3:0] BEQ    = 4'd8;
  localparam logic [3:0] ADDIEX = 4'd9;
  localparam logic [3:0] ADDIWB = 4'd10;
  localparam logic [3:0] JUMP   = 4'd11;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_RTYP = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  logic [3:0] state_nxt;
  logic       pc_write;
  logic       op_bad;

  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = FETCH;
    op_bad    = 1'b0;
    case (state)
      FETCH:  state_nxt = DECODE;
      DECODE: begin
        case (Op)
          OP_LW, OP_SW: state_nxt = MEMADR;
          OP_RTYP:      state_nxt = EXEC;
          OP_BEQ:       state_nxt = BEQ;
          OP_ADDI:      state_nxt = ADDIEX;
          OP_J:         state_nxt = JUMP;
          default: begin
            state_nxt = FETCH;
            op_bad    = 1'b1;
          end
        endcase
      end
      // Op is re-sampled here; anything other than sw is treated as lw.
      MEMADR: state_nxt = (Op == OP_SW) ? MEMWR : MEMRD;
      MEMRD:  state_nxt = MEMWB;
      EXEC:   state_nxt = ALUWB;
      ADDIEX: state_nxt = ADDIWB;
      default: state_nxt = FETCH;
    endcase
  end

  always_comb begin
    IorD     = 1'b0;
    MemWrite = 1'b0;
    IRWrite  = 1'b0;
    RegDst   = 1'b0;
    MemtoReg = 1'b0;
    RegWrite = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = 2'b00;
    ALUOp    = 2'b00;
    PCSrc    = 2'b00;
    Branch   = 1'b0;
    pc_write = 1'b0;
    case (state)
      FETCH:  begin IRWrite = 1'b1; pc_write = 1'b1; ALUSrcB = 2'b01; end
      DECODE: ALUSrcB = 2'b11;
      MEMADR, ADDIEX: begin ALUSrcA = 1'b1; ALUSrcB = 2'b10; end
      MEMRD:  IorD = 1'b1;
      MEMWB:  begin RegWrite = 1'b1; MemtoReg = 1'b1; end
      MEMWR:  begin IorD = 1'b1; MemWrite = 1'b1; end
      EXEC:   begin ALUSrcA = 1'b1; ALUOp = 2'b10; end
      ALUWB:  begin RegWrite = 1'b1; RegDst = 1'b1; end
      ADDIWB: RegWrite = 1'b1;
      BEQ:    begin ALUSrcA = 1'b1; ALUOp = 2'b01; PCSrc = 2'b01; Branch = 1'b1; end
      JUMP:   begin PCSrc = 2'b10; pc_write = 1'b1; end
      default: ;
    endcase
    // Reset holds the whole decode at its idle value so no write escapes mid-instruction.
    if (reset) begin
      IorD     = 1'b0;
      MemWrite = 1'b0;
      IRWrite  = 1'b0;
      RegDst   = 1'b0;
      MemtoReg = 1'b0;
      RegWrite = 1'b0;
      ALUSrcA  = 1'b0;
      ALUSrcB  = 2'b00;
      ALUOp    = 2'b00;
      PCSrc    = 2'b00;
      Branch   = 1'b0;
      pc_write = 1'b0;
    end
  end

  assign PCEn    = pc_write | (Branch & Zero);
  assign Illegal = op_bad & ~reset;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks every instruction class, branch outcomes, illegal opcode and mid-instruction reset.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] Op;
  logic       Zero;
  logic [3:0] state;
  logic       IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, ALUOp, PCSrc;
  logic       Branch, PCEn, Illegal;

  int n_cmp = 0;
  int n_err = 0;

  multicycle_control dut (
    .clk(clk), .reset(reset), .Op(Op), .Zero(Zero), .state(state),
    .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSrc(PCSrc), .Branch(Branch),
    .PCEn(PCEn), .Illegal(Illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Enables that must stay low outside their own states.
  task automatic chk_quiet(input string tag);
    chk({tag, ".MemWrite"}, {7'd0, MemWrite}, 8'd0);
    chk({tag, ".RegWrite"}, {7'd0, RegWrite}, 8'd0);
  endtask

  initial begin
    reset = 1'b1;
    Op    = 6'b000000;
    Zero  = 1'b0;

    // Reset held two cycles
    tick();
    chk("rst1.state", {4'd0, state}, 8'd0);
    chk("rst1.IRWrite", {7'd0, IRWrite}, 8'd0);
    chk("rst1.PCEn", {7'd0, PCEn}, 8'd0);
    chk_quiet("rst1");
    tick();
    chk("rst2.state", {4'd0, state}, 8'd0);
    chk("rst2.PCEn", {7'd0, PCEn}, 8'd0);
    chk("rst2.Illegal", {7'd0, Illegal}, 8'd0);
    reset = 1'b0;
    #1;
    chk("fetch0.IRWrite", {7'd0, IRWrite}, 8'd1);
    chk("fetch0.PCEn", {7'd0, PCEn}, 8'd1);
    chk("fetch0.ALUSrcB", {6'd0, ALUSrcB}, 8'd1);
    chk("fetch0.IorD", {7'd0, IorD}, 8'd0);

    // lw: 0,1,2,3,4,0
    Op = 6'b100011;
    tick();
    chk("lw.s1", {4'd0, state}, 8'd1);
    chk("lw.dec.ALUSrcB", {6'd0, ALUSrcB}, 8'd3);
    chk("lw.dec.PCEn", {7'd0, PCEn}, 8'd0);
    tick();
    chk("lw.s2", {4'd0, state}, 8'd2);
    chk("lw.adr.ALUSrcA", {7'd0, ALUSrcA}, 8'd1);
    chk("lw.adr.ALUSrcB", {6'd0, ALUSrcB}, 8'd2);
    chk_quiet("lw.adr");
    tick();
    chk("lw.s3", {4'd0, state}, 8'd3);
    chk("lw.rd.IorD", {7'd0, IorD}, 8'd1);
    chk_quiet("lw.rd");
    tick();
    chk("lw.s4", {4'd0, state}, 8'd4);
    chk("lw.wb.RegWrite", {7'd0, RegWrite}, 8'd1);
    chk("lw.wb.MemtoReg", {7'd0, MemtoReg}, 8'd1);
    chk("lw.wb.MemWrite", {7'd0, MemWrite}, 8'd0);
    tick();
    chk("lw.s0", {4'd0, state}, 8'd0);
    chk("lw.f.MemtoReg", {7'd0, MemtoReg}, 8'd0);

    // sw: 0,1,2,5,0
    Op = 6'b101011;
    tick();
    chk("sw.s1", {4'd0, state}, 8'd1);
    tick();
    chk("sw.s2", {4'd0, state}, 8'd2);
    chk("sw.adr.MemWrite", {7'd0, MemWrite}, 8'd0);
    tick();
    chk("sw.s5", {4'd0, state}, 8'd5);
    chk("sw.wr.MemWrite", {7'd0, MemWrite}, 8'd1);
    chk("sw.wr.IorD", {7'd0, IorD}, 8'd1);
    chk("sw.wr.RegWrite", {7'd0, RegWrite}, 8'd0);
    tick();
    chk("sw.s0", {4'd0, state}, 8'd0);
    chk("sw.f.MemWrite", {7'd0, MemWrite}, 8'd0);

    // R-type: 0,1,6,7,0
    Op = 6'b000000;
    tick();
    chk("r.s1", {4'd0, state}, 8'd1);
    tick();
    chk("r.s6", {4'd0, state}, 8'd6);
    chk("r.ex.ALUOp", {6'd0, ALUOp}, 8'd2);
    chk("r.ex.ALUSrcA", {7'd0, ALUSrcA}, 8'd1);
    chk("r.ex.ALUSrcB", {6'd0, ALUSrcB}, 8'd0);
    tick();
    chk("r.s7", {4'd0, state}, 8'd7);
    chk("r.wb.RegDst", {7'd0, RegDst}, 8'd1);
    chk("r.wb.RegWrite", {7'd0, RegWrite}, 8'd1);
    chk("r.wb.MemtoReg", {7'd0, MemtoReg}, 8'd0);
    tick();
    chk("r.s0", {4'd0, state}, 8'd0);

    // addi: 0,1,9,10,0
    Op = 6'b001000;
    tick();
    chk("addi.s1", {4'd0, state}, 8'd1);
    tick();
    chk("addi.s9", {4'd0, state}, 8'd9);
    chk("addi.ex.ALUSrcB", {6'd0, ALUSrcB}, 8'd2);
    chk("addi.ex.ALUSrcA", {7'd0, ALUSrcA}, 8'd1);
    chk("addi.ex.ALUOp", {6'd0, ALUOp}, 8'd0);
    tick();
    chk("addi.s10", {4'd0, state}, 8'd10);
    chk("addi.wb.RegDst", {7'd0, RegDst}, 8'd0);
    chk("addi.wb.RegWrite", {7'd0, RegWrite}, 8'd1);
    tick();
    chk("addi.s0", {4'd0, state}, 8'd0);

    // beq taken
    Op = 6'b000100;
    Zero = 1'b1;
    tick();
    chk("beqt.s1", {4'd0, state}, 8'd1);
    tick();
    chk("beqt.s8", {4'd0, state}, 8'd8);
    chk("beqt.PCEn", {7'd0, PCEn}, 8'd1);
    chk("beqt.PCSrc", {6'd0, PCSrc}, 8'd1);
    chk("beqt.ALUOp", {6'd0, ALUOp}, 8'd1);
    chk("beqt.Branch", {7'd0, Branch}, 8'd1);
    tick();
    chk("beqt.s0", {4'd0, state}, 8'd0);

    // beq not taken, then Zero flips within the same BEQ cycle
    Zero = 1'b0;
    tick();
    chk("beqn.s1", {4'd0, state}, 8'd1);
    tick();
    chk("beqn.s8", {4'd0, state}, 8'd8);
    chk("beqn.PCEn", {7'd0, PCEn}, 8'd0);
    Zero = 1'b1;
    #1;
    chk("beqn.zflip.PCEn", {7'd0, PCEn}, 8'd1);
    Zero = 1'b0;
    tick();
    chk("beqn.s0", {4'd0, state}, 8'd0);

    // j: 0,1,11,0
    Op = 6'b000010;
    tick();
    chk("j.s1", {4'd0, state}, 8'd1);
    tick();
    chk("j.s11", {4'd0, state}, 8'd11);
    chk("j.PCSrc", {6'd0, PCSrc}, 8'd2);
    chk("j.PCEn", {7'd0, PCEn}, 8'd1);
    chk("j.IRWrite", {7'd0, IRWrite}, 8'd0);
    tick();
    chk("j.s0", {4'd0, state}, 8'd0);

    // illegal opcode: Illegal only in DECODE, straight back to FETCH
    Op = 6'b111111;
    chk("ill.f.Illegal", {7'd0, Illegal}, 8'd0);
    tick();
    chk("ill.s1", {4'd0, state}, 8'd1);
    chk("ill.dec.Illegal", {7'd0, Illegal}, 8'd1);
    chk("ill.dec.PCEn", {7'd0, PCEn}, 8'd0);
    chk_quiet("ill.dec");
    tick();
    chk("ill.s0", {4'd0, state}, 8'd0);
    chk("ill.f.Illegal2", {7'd0, Illegal}, 8'd0);

    // reset during DECODE of an illegal op suppresses Illegal
    tick();
    chk("illrst.s1", {4'd0, state}, 8'd1);
    reset = 1'b1;
    #1;
    chk("illrst.Illegal", {7'd0, Illegal}, 8'd0);
    tick();
    chk("illrst.s0", {4'd0, state}, 8'd0);
    reset = 1'b0;
    #1;

    // reset in MEMRD of an lw: abandoned, no RegWrite
    Op = 6'b100011;
    tick();
    tick();
    tick();
    chk("lwrst.s3", {4'd0, state}, 8'd3);
    reset = 1'b1;
    #1;
    chk_quiet("lwrst.hold");
    chk("lwrst.IorD", {7'd0, IorD}, 8'd0);
    tick();
    chk("lwrst.s0", {4'd0, state}, 8'd0);
    chk("lwrst.s0.RegWrite", {7'd0, RegWrite}, 8'd0);
    reset = 1'b0;
    #1;
    chk("lwrst.fetch.PCEn", {7'd0, PCEn}, 8'd1);
    tick();
    chk("lwrst.next.s1", {4'd0, state}, 8'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
